// File: rtl/color_config_arbiter.sv
// Round-robin arbiter that shares the colour-config write bus between NUM_REQ sources,
// with burst lock and stall timeout; COLOR_CONFIG_VSYNC_GATE_EN defers writes to vblank.
module color_config_arbiter #(
  parameter int   NUM_REQ        = 2,
  parameter int   C_ADDR_WIDTH   = 8,
  parameter int   C_DATA_WIDTH   = 24,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic VSYNC_ACTIVE   = 1'b0
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [NUM_REQ-1:0]               Req_Valid,
  input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]  Req_Addr,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0]  Req_Data,
  input  logic [NUM_REQ-1:0]               Req_Lock,
  output logic [NUM_REQ-1:0]               Req_Rdy,
  input  logic                             VSync,
  output logic [C_ADDR_WIDTH-1:0]          C_Addr,
  output logic [C_DATA_WIDTH-1:0]          C_Data,
  output logic                             C_Valid,
  input  logic                             C_Rdy,
  output logic [NUM_REQ-1:0]               Grant,
  output logic                             Busy,
  output logic                             Timeout_Err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    ISSUE      = 2'd2,
    HOLD       = 2'd3
  } state_t;

`ifdef COLOR_CONFIG_VSYNC_GATE_EN
  localparam state_t LOAD_STATE = WAIT_BLANK;
`else
  localparam state_t LOAD_STATE = ISSUE;
  logic unused_vsync;
  assign unused_vsync = VSync;
`endif

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [C_ADDR_WIDTH-1:0]  c_addr_q, c_addr_d;
  logic [C_DATA_WIDTH-1:0]  c_data_q, c_data_d;
  logic                     terr_q, terr_d;

  logic [C_ADDR_WIDTH-1:0]  req_addr [NUM_REQ];
  logic [C_DATA_WIDTH-1:0]  req_data [NUM_REQ];
  logic                     rr_found;
  logic [IDX_W-1:0]         rr_idx;
  int                       rr_j;
  logic                     accept;
  logic [IDX_W-1:0]         acc_idx;
  logic [NUM_REQ-1:0]       req_rdy;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i] = Req_Addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
    assign req_data[i] = Req_Data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  // Scan from the highest offset down so the requester right after last_q wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    rr_j     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_j = (int'(last_q) + k) % NUM_REQ;
      if (Req_Valid[rr_j]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(rr_j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    terr_d   = 1'b0;
    req_rdy  = '0;
    accept   = 1'b0;
    acc_idx  = last_q;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          accept          = 1'b1;
          acc_idx         = rr_idx;
          req_rdy[rr_idx] = 1'b1;
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          last_d          = rr_idx;
        end
      end

      WAIT_BLANK: begin
`ifdef COLOR_CONFIG_VSYNC_GATE_EN
        if (VSync == VSYNC_ACTIVE) begin
          state_d = ISSUE;
        end
`else
        state_d = IDLE;
        grant_d = '0;
`endif
      end

      ISSUE: begin
        // A transfer in the expiry cycle takes precedence over the timeout.
        if (C_Rdy) begin
          cnt_d = '0;
          if (Req_Lock[last_q]) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (Req_Valid[last_q]) begin
          accept           = 1'b1;
          acc_idx          = last_q;
          req_rdy[last_q]  = 1'b1;
        end else if (!Req_Lock[last_q]) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (accept) begin
      c_addr_d = req_addr[acc_idx];
      c_data_d = req_data[acc_idx];
      cnt_d    = '0;
      state_d  = LOAD_STATE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      last_q   <= IDX_LAST;
      grant_q  <= '0;
      cnt_q    <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      terr_q   <= terr_d;
    end
  end

  // C_Valid follows the state register so an async reset drops it immediately.
  assign C_Valid     = (state_q == ISSUE);
  assign C_Addr      = c_addr_q;
  assign C_Data      = c_data_q;
  assign Grant       = grant_q;
  assign Busy        = (state_q != IDLE);
  assign Timeout_Err = terr_q;
  assign Req_Rdy     = req_rdy;

  a_rdy_onehot : assert property (@(posedge Clk) disable iff (!Rst) $onehot0(Req_Rdy));
  a_rdy_state  : assert property (@(posedge Clk) disable iff (!Rst)
                                  (Req_Rdy != '0) |-> (state_q == IDLE || state_q == HOLD));
  a_grant_oh   : assert property (@(posedge Clk) disable iff (!Rst) $onehot0(Grant));

endmodule

// File: tb/tb_color_config_arbiter.sv
// Directed bench for color_config_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the single-write, fairness, lock, timeout, reset and gate cases.
module tb_color_config_arbiter;

  localparam int   N    = 2;
  localparam int   AW   = 8;
  localparam int   DW   = 24;
  localparam int   TO   = 16;
  localparam logic VACT = 1'b0;
`ifdef COLOR_CONFIG_VSYNC_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [N-1:0]    Req_Valid = '0;
  logic [N*AW-1:0] Req_Addr = '0;
  logic [N*DW-1:0] Req_Data = '0;
  logic [N-1:0]    Req_Lock = '0;
  logic [N-1:0]    Req_Rdy;
  logic            VSync = 1'b0;
  logic [AW-1:0]   C_Addr;
  logic [DW-1:0]   C_Data;
  logic            C_Valid;
  logic            C_Rdy = 1'b0;
  logic [N-1:0]    Grant;
  logic            Busy;
  logic            Timeout_Err;

  always #5 Clk = ~Clk;

  color_config_arbiter #(
    .NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .VSYNC_ACTIVE(VACT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Addr(Req_Addr),
    .Req_Data(Req_Data), .Req_Lock(Req_Lock), .Req_Rdy(Req_Rdy), .VSync(VSync),
    .C_Addr(C_Addr), .C_Data(C_Data), .C_Valid(C_Valid), .C_Rdy(C_Rdy),
    .Grant(Grant), .Busy(Busy), .Timeout_Err(Timeout_Err)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, whether a write is outstanding (and still gated),
  // how long the current wait has lasted, and the last latched write.
  int            m_owner = -1;
  int            m_last  = N - 1;
  int            m_age   = 0;
  bit            m_pend  = 1'b0;
  bit            m_gated = 1'b0;
  bit            m_terr  = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (Req_Valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic int exp_rdy();
    int w;
    if (m_owner < 0) begin
      w = rr_pick();
      return (w >= 0) ? (1 << w) : 0;
    end
    if (!m_pend && Req_Valid[m_owner]) return 1 << m_owner;
    return 0;
  endfunction

  task automatic m_load(input int i);
    m_pend  = 1'b1;
    m_gated = GATE;
    m_age   = 0;
    m_addr  = Req_Addr[i*AW +: AW];
    m_data  = Req_Data[i*DW +: DW];
  endtask

  task automatic m_release(input bit err);
    m_owner = -1;
    m_pend  = 1'b0;
    m_age   = 0;
    m_terr  = err;
  endtask

  task automatic model_step();
    int w;
    m_terr = 1'b0;
    if (m_owner < 0) begin
      w = rr_pick();
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_load(w);
      end
    end else if (m_pend && m_gated) begin
      if (VSync == VACT) m_gated = 1'b0;
    end else if (m_pend) begin
      if (C_Rdy) begin
        m_pend = 1'b0;
        m_age  = 0;
        if (!Req_Lock[m_owner]) m_release(1'b0);
      end else if (m_age == TO - 1) begin
        m_release(1'b1);
      end else begin
        m_age++;
      end
    end else begin
      if (Req_Valid[m_owner]) m_load(m_owner);
      else if (!Req_Lock[m_owner]) m_release(1'b0);
      else if (m_age == TO - 1) m_release(1'b1);
      else m_age++;
    end
  endtask

  initial forever begin
    @(posedge Clk or negedge Rst);
    if (!Rst) begin
      m_owner = -1; m_last = N - 1; m_age = 0;
      m_pend = 1'b0; m_gated = 1'b0; m_terr = 1'b0;
      m_addr = '0; m_data = '0;
    end else begin
      model_step();
    end
  end

  int xfer_own[$];
  int xfer_addr[$];
  int terr_cnt = 0;
  int cv_cnt   = 0;

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      chk("m_c_valid", 32'(C_Valid), 32'(m_pend && !m_gated));
      chk("m_c_addr", 32'(C_Addr), 32'(m_addr));
      chk("m_c_data", 32'(C_Data), 32'(m_data));
      chk("m_grant", 32'(Grant), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("m_busy", 32'(Busy), 32'(m_owner >= 0));
      chk("m_timeout_err", 32'(Timeout_Err), 32'(m_terr));
      chk("m_req_rdy", 32'(Req_Rdy), exp_rdy());
      if (C_Valid && C_Rdy) begin
        xfer_own.push_back(Grant[1] ? 1 : (Grant[0] ? 0 : -1));
        xfer_addr.push_back(int'(C_Addr));
      end
      if (Timeout_Err) terr_cnt++;
      if (C_Valid) cv_cnt++;
    end
  end

  task automatic clear_mon();
    xfer_own.delete();
    xfer_addr.delete();
    terr_cnt = 0;
    cv_cnt   = 0;
  endtask

  task automatic do_reset();
    Req_Valid = '0; Req_Lock = '0; C_Rdy = 1'b0; VSync = VACT;
    Rst = 1'b0;
    #1;
    chk("rst_c_valid", 32'(C_Valid), 0);
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_terr", 32'(Timeout_Err), 0);
    chk("rst_c_addr", 32'(C_Addr), 0);
    chk("rst_c_data", 32'(C_Data), 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    clear_mon();
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int c = 0;
    while (xfer_own.size() < n && c < budget) begin
      @(negedge Clk); #1;
      c++;
    end
    chk("xfer_count", xfer_own.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_acc;
    logic acc;
    #2;
    chk_en = 1'b1;

    // Single request with downstream always ready.
    do_reset();
    Req_Addr[0 +: AW] = 8'h12;
    Req_Data[0 +: DW] = 24'hFF0000;
    Req_Valid = 2'b01;
    C_Rdy = 1'b1;
    @(negedge Clk);
    chk("single_rdy", 32'(Req_Rdy), 1);
    @(posedge Clk); #1;
    Req_Valid = '0;
`ifdef COLOR_CONFIG_VSYNC_GATE_EN
    @(negedge Clk);
    chk("single_gate_wait", 32'(C_Valid), 0);
    @(posedge Clk); #1;
`endif
    @(negedge Clk);
    chk("single_c_valid", 32'(C_Valid), 1);
    chk("single_c_addr", 32'(C_Addr), 32'h12);
    chk("single_c_data", 32'(C_Data), 32'hFF0000);
    chk("single_grant", 32'(Grant), 1);
    chk("single_rdy_gone", 32'(Req_Rdy), 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("single_idle_busy", 32'(Busy), 0);
    chk("single_idle_grant", 32'(Grant), 0);

    // Fairness: both requesters continuously valid, no lock.
    do_reset();
    C_Rdy = 1'b1;
    Req_Addr = {8'hB1, 8'hA0};
    Req_Valid = 2'b11;
    wait_xfers(6, 40);
    @(posedge Clk); #1;
    Req_Valid = '0;
    if (xfer_own.size() >= 6)
      for (int i = 0; i < 6; i++) chk("fair_order", xfer_own[i], i % 2);

    // Burst lock: requester 1 keeps the bus for three writes while 0 waits.
    do_reset();
    C_Rdy = 1'b1;
    Req_Addr = {8'h21, 8'h05};
    Req_Valid = 2'b10;
    Req_Lock = 2'b10;
    n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      acc = Req_Rdy[1];
      @(posedge Clk); #1;
      Req_Valid[0] = 1'b1;
      if (acc) begin
        n_acc++;
        Req_Addr[AW +: AW] = Req_Addr[AW +: AW] + 8'd1;
        if (n_acc == 3) begin
          Req_Valid[1] = 1'b0;
          Req_Lock[1] = 1'b0;
          break;
        end
      end
    end
    chk("burst_accepts", n_acc, 3);
    wait_xfers(4, 30);
    @(posedge Clk); #1;
    Req_Valid = '0;
    if (xfer_own.size() >= 4) begin
      chk("burst_own0", xfer_own[0], 1);
      chk("burst_own1", xfer_own[1], 1);
      chk("burst_own2", xfer_own[2], 1);
      chk("burst_own3", xfer_own[3], 0);
      chk("burst_addr0", xfer_addr[0], 32'h21);
      chk("burst_addr2", xfer_addr[2], 32'h23);
      chk("burst_addr3", xfer_addr[3], 32'h05);
    end

    // Stall timeout in ISSUE, then a normal write.
    do_reset();
    Req_Addr[0 +: AW] = 8'h40;
    Req_Valid = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    repeat (24) @(negedge Clk);
    #1;
    chk("to_valid_cycles", cv_cnt, 16);
    chk("to_err_pulses", terr_cnt, 1);
    chk("to_grant", 32'(Grant), 0);
    chk("to_busy", 32'(Busy), 0);
    C_Rdy = 1'b1;
    Req_Addr[0 +: AW] = 8'h41;
    Req_Valid = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    wait_xfers(1, 10);
    if (xfer_addr.size() >= 1) chk("to_next_addr", xfer_addr[0], 32'h41);

    // C_Rdy arrives in the expiry cycle: transfer wins, no error.
    do_reset();
    Req_Addr[0 +: AW] = 8'h50;
    Req_Valid = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    for (int c = 0; c < 30 && cv_cnt < 15; c++) begin
      @(negedge Clk); #1;
    end
    @(posedge Clk); #1;
    C_Rdy = 1'b1;
    repeat (4) @(negedge Clk);
    #1;
    chk("race_terr", terr_cnt, 0);
    chk("race_xfers", xfer_own.size(), 1);
    chk("race_valid_cycles", cv_cnt, 16);

    // Locked owner idles in HOLD until the timeout releases it.
    do_reset();
    C_Rdy = 1'b1;
    Req_Addr[0 +: AW] = 8'h60;
    Req_Valid = 2'b01;
    Req_Lock = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    repeat (24) @(negedge Clk);
    #1;
    chk("hold_to_err", terr_cnt, 1);
    chk("hold_to_grant", 32'(Grant), 0);
    chk("hold_to_busy", 32'(Busy), 0);
    chk("hold_to_xfers", xfer_own.size(), 1);
    Req_Lock = '0;

    // Asynchronous reset in the middle of ISSUE.
    do_reset();
    Req_Addr = {8'h71, 8'h70};
    Req_Valid = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    @(posedge Clk); #3;
    chk("pre_rst_c_valid", 32'(C_Valid), 1);
    Rst = 1'b0;
    #1;
    chk("arst_c_valid", 32'(C_Valid), 0);
    chk("arst_grant", 32'(Grant), 0);
    chk("arst_busy", 32'(Busy), 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    clear_mon();
    Req_Valid = 2'b11;
    @(negedge Clk);
    chk("arst_first_winner", 32'(Req_Rdy), 1);
    @(posedge Clk); #1;
    Req_Valid = '0;
    C_Rdy = 1'b1;
    wait_xfers(1, 10);
    if (xfer_own.size() >= 1) chk("arst_xfer_own", xfer_own[0], 0);

`ifdef COLOR_CONFIG_VSYNC_GATE_EN
    // Write held in WAIT_BLANK until VSync reaches its active level.
    do_reset();
    VSync = ~VACT;
    C_Rdy = 1'b1;
    Req_Addr[0 +: AW] = 8'h80;
    Req_Valid = 2'b01;
    @(posedge Clk); #1;
    Req_Valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      chk("gate_hold_valid", 32'(C_Valid), 0);
      chk("gate_hold_terr", 32'(Timeout_Err), 0);
    end
    @(posedge Clk); #1;
    VSync = VACT;
    @(negedge Clk);
    chk("gate_release_cycle", 32'(C_Valid), 0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("gate_valid_rise", 32'(C_Valid), 1);
    chk("gate_addr", 32'(C_Addr), 32'h80);
`endif

    repeat (3) @(posedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
